// File: rtl/shift_issue_if.sv
// Handshake bundle between the decode stage, the shift issue buffer and the shifter.
// The master side is the upstream/downstream environment; the slave side is the issue buffer.
interface shift_issue_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SHW   = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic             in_funct7b5;
    logic             in_use_imm;
    logic [WIDTH-1:0] in_rs1;
    logic [WIDTH-1:0] in_rs2;
    logic [SHW-1:0]   in_imm;
    logic [4:0]       in_rd;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_din;
    logic [SHW-1:0]   out_shamt;
    logic [1:0]       out_mode;
    logic [4:0]       out_rd;

    modport master (
        output in_valid, in_funct3, in_funct7b5, in_use_imm, in_rs1, in_rs2, in_imm, in_rd,
        input  in_ready,
        output out_ready,
        input  out_valid, out_din, out_shamt, out_mode, out_rd
    );

    modport slave (
        input  in_valid, in_funct3, in_funct7b5, in_use_imm, in_rs1, in_rs2, in_imm, in_rd,
        output in_ready,
        input  out_ready,
        output out_valid, out_din, out_shamt, out_mode, out_rd
    );
endinterface

// File: rtl/shift_issue.sv
// Shift instruction issue stage: decodes funct3/funct7 into a shifter mode and buffers
// entries in a two-entry skid buffer so in_ready never depends combinationally on out_ready.
module shift_issue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SHW   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    shift_issue_if.slave bus,
    output logic        illegal,
    output logic [15:0] issue_cnt
);
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] din;
        logic [SHW-1:0]   shamt;
        logic [1:0]       mode;
        logic [4:0]       rd;
    } entry_t;

    state_t state, state_next;
    entry_t main_q, skid_q, in_entry;

    logic       dec_legal;
    logic [1:0] dec_mode;
    logic       accept;
    logic       legal_acc;
    logic       out_xfer;
    logic       load_main_in;
    logic       load_main_skid;
    logic       load_skid;
    logic       rs2_hi_unused;

    // Only the low SHW bits of rs2 form the shift amount; the rest is intentionally ignored.
    assign rs2_hi_unused = ^bus.in_rs2[WIDTH-1:SHW];

    always_comb begin
        dec_legal = 1'b0;
        dec_mode  = 2'b11;
        case (bus.in_funct3)
            3'b001: begin
                dec_legal = 1'b1;
                dec_mode  = 2'b00;
            end
            3'b101: begin
                dec_legal = 1'b1;
                dec_mode  = bus.in_funct7b5 ? 2'b10 : 2'b01;
            end
            default: begin
                dec_legal = 1'b0;
                dec_mode  = 2'b11;
            end
        endcase
    end

    always_comb begin
        in_entry.din   = bus.in_rs1;
        in_entry.shamt = bus.in_use_imm ? bus.in_imm : bus.in_rs2[SHW-1:0];
        in_entry.mode  = dec_mode;
        in_entry.rd    = bus.in_rd;
    end

    assign bus.in_ready  = (state != FULL);
    assign bus.out_valid = (state != EMPTY);

    assign accept    = bus.in_valid && bus.in_ready;
    assign legal_acc = accept && dec_legal && !flush;
    assign out_xfer  = bus.out_valid && bus.out_ready;

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (legal_acc) begin
                        state_next   = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (legal_acc && out_xfer) begin
                        state_next   = ONE;
                        load_main_in = 1'b1;
                    end else if (legal_acc) begin
                        state_next = FULL;
                        load_skid  = 1'b1;
                    end else if (out_xfer) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain of main can happen.
                    if (out_xfer) begin
                        state_next     = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else begin
            illegal <= accept && !dec_legal && !flush;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
        end else if (out_xfer && !flush && (issue_cnt != 16'hFFFF)) begin
            issue_cnt <= issue_cnt + 16'd1;
        end
    end

    // Idle outputs present a pass-through op so the shifter needs no valid qualification.
    assign bus.out_din   = bus.out_valid ? main_q.din   : '0;
    assign bus.out_shamt = bus.out_valid ? main_q.shamt : '0;
    assign bus.out_mode  = bus.out_valid ? main_q.mode  : 2'b11;
    assign bus.out_rd    = bus.out_valid ? main_q.rd    : '0;
endmodule

// File: doc/shift_issue.md
SHIFT_ISSUE -- requirements
Module: shift_issue

Interface
REQ-001 Parameter: WIDTH, 64, datapath width of the shift operand.
REQ-002 Parameter: SHW, 6, shift-amount width (log2 WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream presents a shift instruction.
REQ-006 in_ready  output  1  block can accept; a transfer occurs when in_valid && in_ready at a rising edge.
REQ-007 in_funct3  input  3  instruction funct3 field.
REQ-008 in_funct7b5  input  1  funct7 bit 5; selects arithmetic right shift.
REQ-009 in_use_imm  input  1  1 = shift amount from in_imm, 0 = from in_rs2.
REQ-010 in_rs1  input  WIDTH  value to be shifted.
REQ-011 in_rs2  input  WIDTH  register shift-amount source; only bits [SHW-1:0] are used.
REQ-012 in_imm  input  SHW  immediate shift amount.
REQ-013 in_rd  input  5  destination register tag, carried unchanged.
REQ-014 flush  input  1  synchronous discard of all held entries.
REQ-015 out_valid  output  1  entry presented to the downstream shifter.
REQ-016 out_ready  input  1  downstream accepts; a transfer occurs when out_valid && out_ready at a rising edge.
REQ-017 out_din, out_shamt, out_mode, out_rd  output  WIDTH/SHW/2/5  shifter operand, amount, mode, tag.
REQ-018 illegal  output  1  one-cycle pulse: an accepted instruction had an unsupported encoding.
REQ-019 issue_cnt  output  16  count of completed output transfers.

Function
REQ-020 Decode SHALL be: funct3=001 -> mode 00 (SLL); funct3=101 and funct7b5=0 -> mode 01 (SRL); funct3=101 and funct7b5=1 -> mode 10 (SRA).
REQ-021 Any other funct3 SHALL be illegal: the instruction is accepted, not stored, and illegal pulses high in the cycle after acceptance.
REQ-022 Shift amount SHALL be in_imm when in_use_imm=1, else in_rs2[SHW-1:0]; upper rs2 bits are ignored, no saturation.
REQ-023 out_din SHALL equal the accepted in_rs1 unmodified; out_rd SHALL equal the accepted in_rd.
REQ-024 Storage SHALL be a two-entry skid buffer: a main (output) register and a skid register.
REQ-025 States: EMPTY (no entries), ONE (main valid), FULL (main and skid valid).
REQ-026 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, driven from registered state only (no combinational path from out_ready).
REQ-027 EMPTY + legal accept -> ONE; the entry appears on outputs the next cycle (latency 1).
REQ-028 ONE + accept + output transfer -> ONE with new entry in main; ONE + accept without output transfer -> FULL (new entry into skid); ONE + output transfer only -> EMPTY.
REQ-029 FULL + output transfer -> ONE with skid moved to main; FULL without transfer -> FULL.
REQ-030 Entries SHALL leave in acceptance order; none dropped or duplicated.
REQ-031 While out_valid=1 and out_ready=0, out_din/out_shamt/out_mode/out_rd SHALL be held stable.
REQ-032 An illegal accept SHALL not change state.
REQ-033 flush=1 SHALL force EMPTY at the next edge, discard any same-cycle input transfer, suppress its illegal pulse, and not increment issue_cnt for a same-cycle output transfer.
REQ-034 issue_cnt SHALL increment by 1 on each output transfer and saturate at 16'hFFFF.
REQ-035 When out_valid=0, out_din/out_shamt/out_rd SHALL be 0 and out_mode SHALL be 2'b11 (shifter pass-through).

Reset
REQ-036 rst_n=0 SHALL immediately force EMPTY, out_valid=0, illegal=0, issue_cnt=0, out_din=0, out_shamt=0, out_mode=2'b11, out_rd=0, independent of clk.
REQ-037 in_ready SHALL be 1 during reset and after release; assertion mid-transfer discards all entries.

Verification
REQ-038 Accept funct3=001, use_imm=1, imm=3, rs1=64'h1 with out_ready=1 -> next cycle out_valid=1, out_mode=00, out_shamt=3, out_din=64'h1; issue_cnt=1 after transfer.
REQ-039 Accept funct3=101, f7b5=1, use_imm=0, rs2=64'hFFFF_FFFF_FFFF_FFC1, rs1=64'h8000_0000_0000_0000 -> out_mode=10, out_shamt=1.
REQ-040 out_ready=0; accept tags rd=1,2 -> in_ready=0 after second; release out_ready -> rd=1 then rd=2 in consecutive cycles, issue_cnt=2.
REQ-041 Accept funct3=000 -> illegal=1 for exactly one cycle, out_valid stays 0, issue_cnt unchanged.
REQ-042 FULL state, assert flush for one cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_mode=11; no entry emerges later.
REQ-043 Drop rst_n asynchronously mid-cycle while FULL -> outputs reach REQ-036 values before the next clk edge.
